ras_unwind: RTL and testbench
=============================

RAS_UNWIND -- requirements
Module: ras_unwind

Interface
REQ-001 Parameter: DEPTH_LOG2, default 3; in-flight queue depth D = 2^DEPTH_LOG2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 spec_push  input  1  fetch issued a speculative RAS push (call).
REQ-005 spec_pop  input  1  fetch issued a speculative RAS pop (return).
REQ-006 spec_target  input  32  predicted return target accompanying spec_pop.
REQ-007 commit_valid  input  1  oldest in-flight RAS op retires.
REQ-008 commit_is_ret  input  1  retiring instruction is a return.
REQ-009 commit_target  input  32  resolved jalr target of the retiring return.
REQ-010 flush  input  1  pipeline squash; all uncommitted RAS ops must be undone.
REQ-011 ready  output  1  combinational: state==IDLE and count<D.
REQ-012 rollback_pop  output  1  registered; one-cycle pulse that undoes one speculative push.
REQ-013 rollback_push  output  1  registered; one-cycle pulse that undoes one speculative pop.
REQ-014 mispredict  output  1  registered one-cycle pulse: return target mispredicted.
REQ-015 mispredict_target  output  32  registered corrected target; valid with mispredict, held otherwise.
REQ-016 unwind_done  output  1  registered one-cycle pulse: flush recovery complete.
REQ-017 count  output  DEPTH_LOG2+1  number of in-flight entries.
REQ-018 err  output  1  sticky protocol-violation flag.

Function
REQ-019 Queue: circular FIFO of D entries {type: PUSH/POP, pred_target[31:0]}; head = oldest, tail = youngest.
REQ-020 FSM states: IDLE, UNWIND.
REQ-021 IDLE, ready=1, exactly one of spec_push/spec_pop: append entry at tail (POP stores spec_target), count+1.
REQ-022 spec_push and spec_pop together, or either while ready=0: op ignored, err set.
REQ-023 IDLE, commit_valid, count>0: head entry retired, count-1.
REQ-024 Commit check: commit_is_ret=1 and head type POP and commit_target != pred_target -> mispredict=1, mispredict_target=commit_target on next cycle.
REQ-025 Commit type mismatch (commit_is_ret != (head type==POP)): entry still retired, err set, no mispredict.
REQ-026 commit_valid with count==0, or while in UNWIND: ignored, err set.
REQ-027 Same-cycle append and commit in IDLE: both applied, count unchanged.
REQ-028 Flush in IDLE: same-cycle commit applied first; same-cycle spec op dropped (no err); FSM -> UNWIND if remaining count>0.
REQ-029 Flush in IDLE with remaining count==0: stay IDLE, unwind_done=1 next cycle.
REQ-030 UNWIND: each cycle remove tail entry, count-1, next cycle pulse rollback_pop if entry was PUSH, rollback_push if POP; exactly one pulse per entry, youngest first.
REQ-031 UNWIND exit: cycle removing last entry transitions to IDLE; unwind_done pulses coincident with the last rollback pulse.
REQ-032 Flush during UNWIND: ignored, no err.
REQ-033 rollback_pop and rollback_push never asserted together; at most one of each per cycle.
REQ-034 Pointers wrap modulo D; count saturates neither direction because REQ-022/026 block over/underflow.

Reset
REQ-035 rst_n=0 at a clock edge: state=IDLE, head=tail=0, count=0, err=0, all pulse outputs 0, mispredict_target=0; queue contents not cleared.
REQ-036 Reset mid-UNWIND: unwind aborted, no further rollback pulses, no unwind_done.

Verification
REQ-037 Reset then 3x spec_push -> count=3, ready=1, no rollback pulses.
REQ-038 push, push, pop(spec_target=0x100), flush -> next 3 cycles: rollback_push, rollback_pop, rollback_pop(+unwind_done); count=0.
REQ-039 pop(0x200), commit_valid commit_is_ret=1 commit_target=0x204 -> mispredict=1, mispredict_target=0x204; count=0.
REQ-040 D=8 pushes -> ready=0; 9th push ignored, err=1, count=8.
REQ-041 count=2, commit_valid and flush same cycle -> one rollback pulse for the younger entry, unwind_done with it.
REQ-042 Empty queue flush -> unwind_done next cycle, no rollback pulse; commit on empty -> err=1.

Source files
------------

// File: rtl/ras_unwind.sv
// Return-address-stack speculation tracker: logs speculative RAS push/pop ops in
// order, checks return targets at commit, and replays undo pulses youngest-first on flush.
module ras_unwind #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spec_push,
    input  logic                  spec_pop,
    input  logic [31:0]           spec_target,
    input  logic                  commit_valid,
    input  logic                  commit_is_ret,
    input  logic [31:0]           commit_target,
    input  logic                  flush,
    output logic                  ready,
    output logic                  rollback_pop,
    output logic                  rollback_push,
    output logic                  mispredict,
    output logic [31:0]           mispredict_target,
    output logic                  unwind_done,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  err
);
    localparam int D = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] D_CNT = D[DEPTH_LOG2:0];

    typedef enum logic {IDLE, UNWIND} state_t;

    // Entry storage is intentionally left out of reset.
    logic                  ent_is_pop [D];
    logic [31:0]           ent_tgt    [D];

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d, tail_prev;
    logic [DEPTH_LOG2:0]   count_q, count_d, remain;
    logic                  err_q, err_d;
    logic                  rollback_pop_q, rollback_pop_d;
    logic                  rollback_push_q, rollback_push_d;
    logic                  mispredict_q, mispredict_d;
    logic [31:0]           mispredict_target_q, mispredict_target_d;
    logic                  unwind_done_q, unwind_done_d;
    logic                  append, do_commit, spec_any, spec_both;

    assign ready     = (state_q == IDLE) && (count_q != D_CNT);
    assign spec_any  = spec_push | spec_pop;
    assign spec_both = spec_push & spec_pop;
    assign tail_prev = tail_q - 1'b1;
    assign append    = ready && !flush && spec_any && !spec_both;
    assign do_commit = (state_q == IDLE) && commit_valid && (count_q != '0);
    assign remain    = do_commit ? count_q - 1'b1 : count_q;

    always_comb begin
        state_d             = state_q;
        head_d              = head_q;
        tail_d              = tail_q;
        count_d             = count_q;
        err_d               = err_q;
        rollback_pop_d      = 1'b0;
        rollback_push_d     = 1'b0;
        mispredict_d        = 1'b0;
        mispredict_target_d = mispredict_target_q;
        unwind_done_d       = 1'b0;

        // A flush in IDLE silently drops any same-cycle speculative op.
        if (!(state_q == IDLE && flush) && (spec_both || (spec_any && !ready)))
            err_d = 1'b1;
        if (commit_valid && !do_commit)
            err_d = 1'b1;

        if (do_commit) begin
            head_d = head_q + 1'b1;
            if (commit_is_ret != ent_is_pop[head_q]) begin
                err_d = 1'b1;
            end else if (commit_is_ret && (commit_target != ent_tgt[head_q])) begin
                mispredict_d        = 1'b1;
                mispredict_target_d = commit_target;
            end
        end

        if (append)
            tail_d = tail_q + 1'b1;

        if (append && !do_commit)
            count_d = count_q + 1'b1;
        else if (do_commit && !append)
            count_d = count_q - 1'b1;

        if (state_q == IDLE && flush) begin
            if (remain != '0)
                state_d = UNWIND;
            else
                unwind_done_d = 1'b1;
        end

        // Peel one entry off the young end per cycle; the last one ends the unwind.
        if (state_q == UNWIND) begin
            tail_d  = tail_prev;
            count_d = count_q - 1'b1;
            if (ent_is_pop[tail_prev])
                rollback_push_d = 1'b1;
            else
                rollback_pop_d = 1'b1;
            if (count_q == 1) begin
                state_d       = IDLE;
                unwind_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            head_q              <= '0;
            tail_q              <= '0;
            count_q             <= '0;
            err_q               <= 1'b0;
            rollback_pop_q      <= 1'b0;
            rollback_push_q     <= 1'b0;
            mispredict_q        <= 1'b0;
            mispredict_target_q <= '0;
            unwind_done_q       <= 1'b0;
        end else begin
            state_q             <= state_d;
            head_q              <= head_d;
            tail_q              <= tail_d;
            count_q             <= count_d;
            err_q               <= err_d;
            rollback_pop_q      <= rollback_pop_d;
            rollback_push_q     <= rollback_push_d;
            mispredict_q        <= mispredict_d;
            mispredict_target_q <= mispredict_target_d;
            unwind_done_q       <= unwind_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && append) begin
            ent_is_pop[tail_q] <= spec_pop;
            ent_tgt[tail_q]    <= spec_target;
        end
    end

    assign rollback_pop      = rollback_pop_q;
    assign rollback_push     = rollback_push_q;
    assign mispredict        = mispredict_q;
    assign mispredict_target = mispredict_target_q;
    assign unwind_done       = unwind_done_q;
    assign count             = count_q;
    assign err               = err_q;
endmodule

// File: tb/tb_ras_unwind.sv
// Directed bench for ras_unwind: hand-computed expectations, sampled 1ns after each rising edge.
module tb_ras_unwind;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spec_push = 1'b0, spec_pop = 1'b0;
    logic [31:0] spec_target = '0;
    logic        commit_valid = 1'b0, commit_is_ret = 1'b0;
    logic [31:0] commit_target = '0;
    logic        flush = 1'b0;
    logic        ready, rollback_pop, rollback_push, mispredict, unwind_done, err;
    logic [31:0] mispredict_target;
    logic [3:0]  count;

    int checks = 0;
    int failures = 0;

    ras_unwind #(.DEPTH_LOG2(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .spec_push(spec_push), .spec_pop(spec_pop), .spec_target(spec_target),
        .commit_valid(commit_valid), .commit_is_ret(commit_is_ret), .commit_target(commit_target),
        .flush(flush), .ready(ready), .rollback_pop(rollback_pop), .rollback_push(rollback_push),
        .mispredict(mispredict), .mispredict_target(mispredict_target),
        .unwind_done(unwind_done), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then return all strobes to idle.
    task automatic cyc(input logic pu, input logic po, input logic [31:0] st,
                       input logic cv, input logic cr, input logic [31:0] ct, input logic fl);
        spec_push = pu; spec_pop = po; spec_target = st;
        commit_valid = cv; commit_is_ret = cr; commit_target = ct; flush = fl;
        @(posedge clk); #1;
        spec_push = 0; spec_pop = 0; spec_target = 0;
        commit_valid = 0; commit_is_ret = 0; commit_target = 0; flush = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 0; idle(); idle(); rst_n = 1;
    endtask

    // Expected {rollback_push, rollback_pop, unwind_done} and count.
    task automatic chk_rb(input string tag, input logic [2:0] exp_rb, input logic [3:0] exp_cnt);
        check({tag, "_rb"}, {29'd0, rollback_push, rollback_pop, unwind_done}, {29'd0, exp_rb});
        check({tag, "_cnt"}, {28'd0, count}, {28'd0, exp_cnt});
    endtask

    initial begin
        do_reset();
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_pulses", {28'd0, rollback_pop, rollback_push, mispredict, unwind_done}, 32'd0);
        check("rst_mpt", mispredict_target, 32'd0);

        // Three pushes, then unwind them.
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        check("p3_count", {28'd0, count}, 32'd3);
        check("p3_ready", {31'd0, ready}, 32'd1);
        chk_rb("p3", 3'b000, 4'd3);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk_rb("p3_fl", 3'b000, 4'd3);
        check("p3_unw_ready", {31'd0, ready}, 32'd0);
        idle(); chk_rb("p3_u1", 3'b010, 4'd2);
        idle(); chk_rb("p3_u2", 3'b010, 4'd1);
        idle(); chk_rb("p3_u3", 3'b011, 4'd0);

        // push, push, pop(0x100), flush: POP undone first.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h100, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(); chk_rb("ppp_u1", 3'b100, 4'd2);
        idle(); chk_rb("ppp_u2", 3'b010, 4'd1);
        idle(); chk_rb("ppp_u3", 3'b011, 4'd0);
        idle(); chk_rb("ppp_after", 3'b000, 4'd0);
        check("ppp_ready", {31'd0, ready}, 32'd1);
        check("ppp_err", {31'd0, err}, 32'd0);

        // Return target mispredict.
        cyc(0, 1, 32'h200, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'h204, 0);
        check("mp_flag", {31'd0, mispredict}, 32'd1);
        check("mp_tgt", mispredict_target, 32'h204);
        check("mp_count", {28'd0, count}, 32'd0);
        idle();
        check("mp_pulse", {31'd0, mispredict}, 32'd0);
        check("mp_hold", mispredict_target, 32'h204);
        // Correct prediction: no mispredict, target held.
        cyc(0, 1, 32'h300, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'h300, 0);
        check("ok_flag", {31'd0, mispredict}, 32'd0);
        check("ok_hold", mispredict_target, 32'h204);

        // Same-cycle append and commit keep count.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        check("ac_count", {28'd0, count}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(); chk_rb("ac_u1", 3'b011, 4'd0);

        // count=2 (push, pop), commit+flush: only the younger POP unwound.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h10, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 1);
        chk_rb("cf_fl", 3'b000, 4'd1);
        idle(); chk_rb("cf_u1", 3'b101, 4'd0);
        idle(); chk_rb("cf_after", 3'b000, 4'd0);
        check("cf_err", {31'd0, err}, 32'd0);

        // Flush with a spec op on an empty queue: op dropped, no err.
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk_rb("efl", 3'b001, 4'd0);
        check("efl_err", {31'd0, err}, 32'd0);

        // Commit type mismatch: retired, err, no mispredict.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'h55, 0);
        check("tm_count", {28'd0, count}, 32'd0);
        check("tm_err", {31'd0, err}, 32'd1);
        check("tm_mp", {31'd0, mispredict}, 32'd0);
        do_reset();
        check("tm_rst_err", {31'd0, err}, 32'd0);

        // Fill to D=8, overflow push flagged.
        repeat (8) cyc(1, 0, 0, 0, 0, 0, 0);
        check("full_count", {28'd0, count}, 32'd8);
        check("full_ready", {31'd0, ready}, 32'd0);
        check("full_err0", {31'd0, err}, 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("ovf_err", {31'd0, err}, 32'd1);
        check("ovf_count", {28'd0, count}, 32'd8);
        do_reset();

        // Empty flush, then commit on empty.
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk_rb("emp_fl", 3'b001, 4'd0);
        idle(); chk_rb("emp_after", 3'b000, 4'd0);
        check("emp_err0", {31'd0, err}, 32'd0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("emp_commit_err", {31'd0, err}, 32'd1);
        do_reset();

        // Simultaneous push and pop: ignored, err.
        cyc(1, 1, 32'h44, 0, 0, 0, 0);
        check("both_count", {28'd0, count}, 32'd0);
        check("both_err", {31'd0, err}, 32'd1);
        do_reset();

        // Reset in the middle of an unwind aborts it.
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(); chk_rb("ra_u1", 3'b010, 4'd2);
        rst_n = 0; idle(); rst_n = 1;
        chk_rb("ra_rst", 3'b000, 4'd0);
        idle(); chk_rb("ra_a1", 3'b000, 4'd0);
        idle(); chk_rb("ra_a2", 3'b000, 4'd0);
        check("ra_ready", {31'd0, ready}, 32'd1);

        // Pointer wrap: advance head/tail to 6, then four pops span the wrap.
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("wr_count0", {28'd0, count}, 32'd0);
        cyc(0, 1, 32'hA0, 0, 0, 0, 0);
        cyc(0, 1, 32'hB0, 0, 0, 0, 0);
        cyc(0, 1, 32'hC0, 0, 0, 0, 0);
        cyc(0, 1, 32'hD0, 0, 0, 0, 0);
        check("wr_count4", {28'd0, count}, 32'd4);
        cyc(0, 0, 0, 1, 1, 32'hA0, 0);
        check("wr_mp_a", {31'd0, mispredict}, 32'd0);
        cyc(0, 0, 0, 1, 1, 32'hB0, 0);
        check("wr_mp_b", {31'd0, mispredict}, 32'd0);
        cyc(0, 0, 0, 1, 1, 32'hC0, 0);
        check("wr_mp_c", {31'd0, mispredict}, 32'd0);
        cyc(0, 0, 0, 1, 1, 32'hD4, 0);
        check("wr_mp_d", {31'd0, mispredict}, 32'd1);
        check("wr_mpt", mispredict_target, 32'hD4);
        check("wr_count", {28'd0, count}, 32'd0);
        check("wr_err", {31'd0, err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
